vproc_vreg_wr_arbiter: RTL

VPROC_VREG_WR_ARBITER -- requirements
Module: vproc_vreg_wr_arbiter

---
 rtl/vproc_vreg_wr_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/vproc_vreg_wr_arbiter.sv
// rtl/vproc_vreg_wr_arbiter.sv - round-robin vector register file write arbiter with burst locking
// Define VPROC_VREG_WR_BUF_EN to register the write port (one cycle latency).
module vproc_vreg_wr_arbiter #(
    parameter int REQ_CNT = 6,
    parameter int VREG_W  = 128
) (
    input  logic                              clk_i,
    input  logic                              sync_rst_ni,
    input  logic [REQ_CNT-1:0]                req_valid_i,
    output logic [REQ_CNT-1:0]                req_ready_o,
    input  logic [REQ_CNT-1:0]                req_last_i,
    input  logic [5*REQ_CNT-1:0]              req_addr_i,
    input  logic [VREG_W*REQ_CNT-1:0]         req_data_i,
    input  logic [(VREG_W/8)*REQ_CNT-1:0]     req_be_i,
    output logic                              wr_en_o,
    output logic [4:0]                        wr_addr_o,
    output logic [VREG_W-1:0]                 wr_data_o,
    output logic [VREG_W/8-1:0]               wr_be_o,
    output logic [$clog2(REQ_CNT)-1:0]        grant_idx_o
);

    localparam int IDX_W = $clog2(REQ_CNT);
    localparam int BE_W  = VREG_W / 8;

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0]   hi_idx, lo_idx, sel_idx;
    logic               hi_found, lo_found, sel_valid, xfer;
    logic [4:0]         mux_addr;
    logic [VREG_W-1:0]  mux_data;
    logic [BE_W-1:0]    mux_be;
    logic               mux_last;

    // Round-robin search: the lowest valid index at or above rr_ptr wins, else the lowest below it.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = REQ_CNT - 1; j >= 0; j--) begin
            if (req_valid_i[j]) begin
                if (j >= int'(rr_ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(j);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = IDX_W'(j);
                end
            end
        end
        if (state_q == LOCKED) begin
            sel_idx   = lock_idx_q;
            sel_valid = req_valid_i[lock_idx_q];
        end else if (hi_found) begin
            sel_idx   = hi_idx;
            sel_valid = 1'b1;
        end else begin
            sel_idx   = lo_idx;
            sel_valid = lo_found;
        end
        xfer = sel_valid & sync_rst_ni;
    end

    always_comb begin
        mux_addr    = '0;
        mux_data    = '0;
        mux_be      = '0;
        mux_last    = 1'b0;
        req_ready_o = '0;
        for (int j = 0; j < REQ_CNT; j++) begin
            if (sel_idx == IDX_W'(j)) begin
                mux_addr       = req_addr_i[j*5 +: 5];
                mux_data       = req_data_i[j*VREG_W +: VREG_W];
                mux_be         = req_be_i[j*BE_W +: BE_W];
                mux_last       = req_last_i[j];
                req_ready_o[j] = xfer;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        if (xfer) begin
            if (mux_last) begin
                state_d  = IDLE;
                rr_ptr_d = (sel_idx == IDX_W'(REQ_CNT - 1)) ? '0 : sel_idx + 1'b1;
            end else if (state_q == IDLE) begin
                state_d    = LOCKED;
                lock_idx_d = sel_idx;
            end
        end
    end

    assign grant_idx_o = sel_idx;

`ifdef VPROC_VREG_WR_BUF_EN
    logic               wr_en_q;
    logic [4:0]         wr_addr_q;
    logic [VREG_W-1:0]  wr_data_q;
    logic [BE_W-1:0]    wr_be_q;
    logic               wr_en_d;
    logic [4:0]         wr_addr_d;
    logic [VREG_W-1:0]  wr_data_d;
    logic [BE_W-1:0]    wr_be_d;

    always_comb begin
        wr_en_d   = xfer;
        wr_addr_d = mux_addr;
        wr_data_d = mux_data;
        wr_be_d   = mux_be;
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign wr_be_o   = wr_be_q;
`else
    assign wr_en_o   = xfer;
    assign wr_addr_o = mux_addr;
    assign wr_data_o = mux_data;
    assign wr_be_o   = mux_be;
`endif

    always_ff @(posedge clk_i) begin
        if (!sync_rst_ni) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
`ifdef VPROC_VREG_WR_BUF_EN
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_be_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
`ifdef VPROC_VREG_WR_BUF_EN
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_be_q    <= wr_be_d;
`endif
        end
    end

endmodule
